// File: rtl/seq_alu_core.sv
// Multi-cycle unsigned integer ALU: single-cycle ADD/SUB, iterative shift-add MUL
// and restoring DIV (WIDTH iterations), with valid/ready on operand and result sides.
//
// Handshake: an operand transfer happens on a rising edge where in_valid, in_ready
// and ena are all high; a result transfer happens on a rising edge where out_valid,
// out_ready and ena are all high. Once asserted, out_valid and the result/flags hold
// steady until the result transfer completes. in_ready is high only in IDLE (and
// only with ena high and rst_n released), so no operand transfer can share a cycle
// with a result transfer.
module seq_alu_core #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag_c,
    output logic                 flag_z,
    output logic                 flag_dz,
    output logic [1:0]           dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    // opnd holds the multiplicand (MUL) or the divisor (DIV) during iteration.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    // {hi, lo} is the shared working register and also the visible result:
    // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient}.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;

    assign in_ready  = rst_n && ena && (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = {hi_q, lo_q};
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign flag_dz   = dz_q;
    assign dbg_state = state_q;

    // Arithmetic for the accept cycle and for one MUL/DIV iteration.
    always_comb begin
        add_sum   = {1'b0, a} + {1'b0, b};
        sub_diff  = {1'b0, a} - {1'b0, b};
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        // Partial remainder is always below 2*divisor, so bit WIDTH is a clean borrow.
        div_trial = div_shift - {1'b0, opnd_q};
    end

    // Next-state, datapath and flag updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        c_d     = c_q;
        z_d     = z_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = op;
                    cnt_d = '0;
                    c_d   = 1'b0;
                    z_d   = 1'b0;
                    dz_d  = 1'b0;
                    case (op)
                        OP_ADD: begin
                            hi_d    = '0;
                            lo_d    = add_sum[WIDTH-1:0];
                            c_d     = add_sum[WIDTH];
                            z_d     = (add_sum[WIDTH-1:0] == '0);
                            state_d = ST_DONE;
                        end
                        OP_SUB: begin
                            hi_d    = '0;
                            lo_d    = sub_diff[WIDTH-1:0];
                            c_d     = sub_diff[WIDTH];
                            z_d     = (sub_diff[WIDTH-1:0] == '0);
                            state_d = ST_DONE;
                        end
                        OP_MUL: begin
                            hi_d    = '0;
                            lo_d    = b;
                            opnd_d  = a;
                            state_d = ST_BUSY;
                        end
                        default: begin
                            if (b == '0) begin
                                // Divide by zero: quotient saturates, remainder is the dividend.
                                hi_d    = a;
                                lo_d    = '1;
                                dz_d    = 1'b1;
                                state_d = ST_DONE;
                            end else begin
                                hi_d    = '0;
                                lo_d    = a;
                                opnd_d  = b;
                                state_d = ST_BUSY;
                            end
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                if (op_q == OP_MUL) begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end else if (!div_trial[WIDTH]) begin
                    hi_d = div_trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    c_d     = (op_q == OP_MUL) && (hi_d != '0);
                    z_d     = ({hi_d, lo_d} == '0);
                    dz_d    = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register: synchronous active-low reset, everything frozen while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            dz_q    <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            c_q     <= c_d;
            z_q     <= z_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_seq_alu_core.sv
// Bench for seq_alu_core (WIDTH=8): directed cases plus randomized traffic with
// random backpressure, checked by a scoreboard against an arithmetic reference.
module tb_seq_alu_core;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           ena;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           flag_c;
    logic           flag_z;
    logic           flag_dz;
    logic [1:0]     dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int bp_mode = 0;   // 0: always ready, 1: random, 2: hold low

    // Entry layout: {latency[7:0], result[15:0], c, z, dz}
    logic [26:0] exp_q[$];
    int          acc_q[$];

    seq_alu_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_dz   (flag_dz),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: plain arithmetic on the operation definitions.
    function automatic logic [26:0] model(input logic [1:0] o, input int x, input int y, input int extra);
        int r;
        int lat;
        logic c;
        logic dz;
        c   = 1'b0;
        dz  = 1'b0;
        lat = W + 1;
        case (o)
            2'd0: begin r = (x + y) % 256; c = (x + y) > 255; lat = 1; end
            2'd1: begin r = (x - y + 256) % 256; c = x < y; lat = 1; end
            2'd2: begin r = x * y; c = r > 255; end
            default: begin
                if (y == 0) begin
                    r = x * 256 + 255; dz = 1'b1; lat = 1;
                end else begin
                    r = (x % y) * 256 + (x / y);
                end
            end
        endcase
        lat = lat + extra;
        return {lat[7:0], r[15:0], c, (r == 0), dz};
    endfunction

    // Backpressure driver (updates at #2 after the edge so mode changes at #1 take effect)
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Issue one operation; returns #1 after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int extra);
        int t;
        @(posedge clk);
        #1;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 300) begin
                fail_now("issue_timeout");
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(model(o, int'(x), int'(y), extra));
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs: they must have no effect after accept.
        op = 2'($urandom);
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 || !in_ready) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 500) begin
                fail_now("drain_timeout");
                return;
            end
        end
    endtask

    // Monitor: compare every cycle a result is presented, pop on handshake.
    initial begin
        logic [26:0] e;
        bit seen;
        seen = 0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        seen = 1;
                        chk("latency", 32'(cyc - acc_q[0]), 32'(e[26:19]));
                    end
                    chk("result", 32'(result), 32'(e[18:3]));
                    chk("flag_c", 32'(flag_c), 32'(e[2]));
                    chk("flag_z", 32'(flag_z), 32'(e[1]));
                    chk("flag_dz", 32'(flag_dz), 32'(e[0]));
                    chk("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (out_ready && ena) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    // Main stimulus
    initial begin
        logic [1:0] ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n = 1'b0;
        ena = 1'b1;
        in_valid = 1'b0;
        op = 2'd0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", 32'({flag_c, flag_z, flag_dz}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Directed arithmetic cases
        issue(2'd0, 8'd200, 8'd100, 0);
        issue(2'd1, 8'd5, 8'd7, 0);
        issue(2'd1, 8'd9, 8'd9, 0);
        issue(2'd2, 8'd255, 8'd255, 0);
        issue(2'd2, 8'd15, 8'd17, 0);
        issue(2'd3, 8'd100, 8'd7, 0);
        issue(2'd3, 8'd42, 8'd0, 0);
        issue(2'd0, 8'd0, 8'd0, 0);
        issue(2'd2, 8'd0, 8'd123, 0);
        issue(2'd3, 8'd3, 8'd200, 0);
        wait_idle();

        // Backpressure: hold DONE for 5 cycles, then release
        bp_mode = 2;
        issue(2'd2, 8'd255, 8'd255, 0);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (!out_valid) fail_now("bp_wait_timeout");
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid_held", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        bp_mode = 0;
        @(posedge clk);
        #1;
        chk("bp_release_idle", 32'(dbg_state), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset mid-MUL: nothing must come out
        issue(2'd2, 8'd77, 8'd99, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_in_ready", 32'(in_ready), 32'd0);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            chk("aborted_no_out_valid", 32'(out_valid), 32'd0);
        end
        issue(2'd0, 8'd1, 8'd1, 0);
        wait_idle();

        // ena low for 3 cycles mid-DIV: latency grows by 3
        issue(2'd3, 8'd250, 8'd13, 3);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        ena = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("ena_low_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        ena = 1'b1;
        wait_idle();

        // Randomized traffic with random backpressure
        bp_mode = 1;
        for (int i = 0; i < 80; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            issue(ro, ra, rb, 0);
        end
        wait_idle();
        bp_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
